gf2_mat_solve: RTL and testbench

Sequential GF(2) linear-system solver, the inverse of the binary matrix-vector multiplier. Given an N×N binary matrix A and a binary vector u, it finds v such that A·v = u. Row products are AND and sums are XOR. It uses Gauss-Jordan elimination, one column per two clock cycles, and flags singular matrices. It sits downstream of any block that produced u = A·v and recovers v, with valid/ready handshakes on both sides.

---
 rtl/gf2_mat_solve_if.sv | 24 ++
 rtl/gf2_mat_solve.sv | 233 +++++++++++++++++++++++
 tb/tb_gf2_mat_solve.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf2_mat_solve_if.sv
// Operand/result handshake bundle for gf2_mat_solve: (a, u) in, (v, singular, check_err) out.
interface gf2_mat_solve_if #(
    parameter int N = 2
);
    logic           in_valid;
    logic           in_ready;
    logic [N*N-1:0] a;
    logic [N-1:0]   u;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   v;
    logic           singular;
    logic           check_err;

    modport master (
        output in_valid, a, u, out_ready,
        input  in_ready, out_valid, v, singular, check_err
    );

    modport slave (
        input  in_valid, a, u, out_ready,
        output in_ready, out_valid, v, singular, check_err
    );
endinterface

// File: rtl/gf2_mat_solve.sv
// GF(2) Gauss-Jordan solver: finds v with A*v = u, one column per PIVOT+ELIM cycle pair.
// Optional GF2_SOLVE_CHECK_EN keeps the operands and re-multiplies A*v to raise check_err.
module gf2_mat_solve #(
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gf2_mat_solve_if.slave bus
);
    localparam int CW = $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PIVOT = 3'd1;
    localparam logic [2:0] S_ELIM  = 3'd2;
`ifdef GF2_SOLVE_CHECK_EN
    localparam logic [2:0] S_CHECK = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_r;
    logic [N-1:0]  m_r [N];
    logic [N-1:0]  r_r;
    logic [CW-1:0] c_r;
    logic [N-1:0]  v_r;
    logic          singular_r;
    logic          out_valid_r;

    logic          piv_found_s;
    logic [CW-1:0] piv_idx_s;
    logic [N-1:0]  swap_m_s [N];
    logic [N-1:0]  swap_r_s;
    logic [N-1:0]  elim_m_s [N];
    logic [N-1:0]  elim_r_s;
    logic          last_col_s;
    logic          accept_s;

`ifdef GF2_SOLVE_CHECK_EN
    logic [N*N-1:0] a_r;
    logic [N-1:0]   u_r;
    logic           check_err_r;

    function automatic logic parity(input logic [N-1:0] x);
        return ^x;
    endfunction

    function automatic logic [N-1:0] mat_vec(input logic [N*N-1:0] mat, input logic [N-1:0] vec);
        logic [N-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            res[i] = parity(mat[i*N +: N] & vec);
        end
        return res;
    endfunction
`endif

    assign accept_s   = bus.in_valid && (state_r == S_IDLE);
    assign last_col_s = (c_r == CW'(N - 1));

    // Pivot search: lowest row at or below column c with a 1 in column c.
    always_comb begin
        piv_found_s = 1'b0;
        piv_idx_s   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((i >= int'(c_r)) && m_r[i][c_r]) begin
                piv_found_s = 1'b1;
                piv_idx_s   = CW'(i);
            end else begin
                piv_found_s = piv_found_s;
                piv_idx_s   = piv_idx_s;
            end
        end
    end

    // Exchange pivot row with row c (identity when they coincide).
    always_comb begin
        swap_m_s = m_r;
        swap_r_s = r_r;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == c_r) begin
                swap_m_s[i] = m_r[piv_idx_s];
                swap_r_s[i] = r_r[piv_idx_s];
            end else if (CW'(i) == piv_idx_s) begin
                swap_m_s[i] = m_r[c_r];
                swap_r_s[i] = r_r[c_r];
            end else begin
                swap_m_s[i] = m_r[i];
                swap_r_s[i] = r_r[i];
            end
        end
    end

    // Clear column c in every other row in a single step.
    always_comb begin
        elim_m_s = m_r;
        elim_r_s = r_r;
        for (int i = 0; i < N; i++) begin
            if ((CW'(i) != c_r) && m_r[i][c_r]) begin
                elim_m_s[i] = m_r[i] ^ m_r[c_r];
                elim_r_s[i] = r_r[i] ^ r_r[c_r];
            end else begin
                elim_m_s[i] = m_r[i];
                elim_r_s[i] = r_r[i];
            end
        end
    end

    // Sequencer and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            v_r         <= '0;
            singular_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r    <= S_PIVOT;
                        singular_r <= 1'b0;
                    end
                end
                S_PIVOT: begin
                    if (piv_found_s) begin
                        state_r <= S_ELIM;
                    end else begin
                        state_r     <= S_DONE;
                        singular_r  <= 1'b1;
                        v_r         <= '0;
                        out_valid_r <= 1'b1;
                    end
                end
                S_ELIM: begin
                    if (last_col_s) begin
                        v_r        <= elim_r_s;
                        singular_r <= 1'b0;
`ifdef GF2_SOLVE_CHECK_EN
                        state_r    <= S_CHECK;
`else
                        state_r     <= S_DONE;
                        out_valid_r <= 1'b1;
`endif
                    end else begin
                        state_r <= S_PIVOT;
                    end
                end
`ifdef GF2_SOLVE_CHECK_EN
                S_CHECK: begin
                    state_r     <= S_DONE;
                    out_valid_r <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Working matrix, rhs and column index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_r[i] <= '0;
            end
            r_r <= '0;
            c_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < N; i++) begin
                            m_r[i] <= bus.a[i*N +: N];
                        end
                        r_r <= bus.u;
                        c_r <= '0;
                    end
                end
                S_PIVOT: begin
                    if (piv_found_s) begin
                        for (int i = 0; i < N; i++) begin
                            m_r[i] <= swap_m_s[i];
                        end
                        r_r <= swap_r_s;
                    end
                end
                S_ELIM: begin
                    for (int i = 0; i < N; i++) begin
                        m_r[i] <= elim_m_s[i];
                    end
                    r_r <= elim_r_s;
                    if (!last_col_s) begin
                        c_r <= c_r + CW'(1'b1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GF2_SOLVE_CHECK_EN
    // Operand copies and the A*v == u self-check; singular exits never reach CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            u_r         <= '0;
            check_err_r <= 1'b0;
        end else if (accept_s) begin
            a_r         <= bus.a;
            u_r         <= bus.u;
            check_err_r <= 1'b0;
        end else if (state_r == S_CHECK) begin
            check_err_r <= (mat_vec(a_r, v_r) != u_r);
        end
    end

    assign bus.check_err = check_err_r;
`else
    assign bus.check_err = 1'b0;
`endif

    assign bus.in_ready  = (state_r == S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.v         = v_r;
    assign bus.singular  = singular_r;
endmodule

// File: tb/tb_gf2_mat_solve.sv
// Bench for gf2_mat_solve: brute-force GF(2) reference, per-cycle compare on N=2, directed/random N=4.
`timescale 1ns/1ps
module tb_gf2_mat_solve;
`ifdef GF2_SOLVE_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    typedef struct packed {
        logic [3:0] v;
        logic       sing;
        logic [7:0] lat;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gf2_mat_solve_if #(.N(2)) b2 ();
    gf2_mat_solve_if #(.N(4)) b4 ();

    gf2_mat_solve #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    gf2_mat_solve #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Row i of A dotted with w, sums taken modulo 2.
    function automatic logic [3:0] mv(input int n, input logic [15:0] a, input logic [3:0] w);
        logic [3:0] res;
        logic       s;
        res = 4'd0;
        for (int i = 0; i < n; i++) begin
            s = 1'b0;
            for (int j = 0; j < n; j++) s = s ^ (a[i*n+j] & w[j]);
            res[i] = s;
        end
        return res;
    endfunction

    // Failing column = smallest top bit of any nonzero null vector; else the unique solution.
    function automatic res_t ref_solve(input int n, input logic [15:0] a, input logic [3:0] u);
        res_t r;
        int   k;
        int   top;
        k = n;
        for (int w = 1; w < (1 << n); w++) begin
            if (mv(n, a, 4'(w)) == 4'd0) begin
                top = 0;
                for (int b = 0; b < n; b++) if (((w >> b) & 1) == 1) top = b;
                if (top < k) k = top;
            end
        end
        r.v = 4'd0;
        if (k < n) begin
            r.sing = 1'b1;
            r.lat  = 8'(2 * k + 1);
        end else begin
            r.sing = 1'b0;
            r.lat  = 8'(2 * n + CHK);
            for (int w = 0; w < (1 << n); w++) if (mv(n, a, 4'(w)) == u) r.v = 4'(w);
        end
        return r;
    endfunction

    // N=2 transaction model: who holds the block and when its result is due.
    logic busy2 = 1'b0;
    int   e2    = 0;
    int   acc2  = 0;
    res_t er2;
    logic exp_ov2;
    int   sing2_cnt  = 0;
    int   nsing2_cnt = 0;

    assign exp_ov2 = busy2 && (e2 >= acc2 + int'(er2.lat));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy2 <= 1'b0;
        end else begin
            e2 <= e2 + 1;
            if (!busy2 && b2.in_valid) begin
                busy2 <= 1'b1;
                acc2  <= e2 + 1;
                er2   <= ref_solve(2, {12'd0, b2.a}, {2'd0, b2.u});
            end else if (exp_ov2 && b2.out_ready) begin
                busy2 <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset2", 32'({b2.out_valid, b2.in_ready, b2.v, b2.singular, b2.check_err}),
                  32'(6'b010000));
        end else begin
            check("flow2", 32'({b2.out_valid, b2.in_ready}), 32'({exp_ov2, !busy2}));
            if (exp_ov2) begin
                check("result2", 32'({b2.v, b2.singular, b2.check_err}),
                      32'({er2.v[1:0], er2.sing, 1'b0}));
                if (b2.out_ready) begin
                    if (b2.singular) sing2_cnt <= sing2_cnt + 1;
                    else             nsing2_cnt <= nsing2_cnt + 1;
                end
            end
        end
    end

    task automatic solve2(input logic [3:0] a, input logic [1:0] u, input int hold);
        int n;
        b2.a = a;
        b2.u = u;
        b2.in_valid  = 1'b1;
        b2.out_ready = (hold == 0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!busy2 && n < 40);
        check("accept2", 32'(busy2), 32'd1);
        b2.in_valid = 1'($urandom_range(0, 1));
        b2.a = 4'($urandom);
        b2.u = 2'($urandom);
        if (hold > 0) begin
            n = 0;
            while (!exp_ov2 && n < 40) begin
                @(posedge clk); #1; n++;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            b2.out_ready = 1'b1;
        end
        b2.in_valid = 1'b0;
        n = 0;
        while (busy2 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("consume2", 32'(busy2), 32'd0);
        b2.out_ready = 1'b0;
    endtask

    task automatic solve4(input logic [15:0] a, input logic [3:0] u);
        res_t r;
        int   lat;
        r = ref_solve(4, a, u);
        check("ready4_idle", 32'(b4.in_ready), 32'd1);
        b4.a = a;
        b4.u = u;
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b0;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        b4.a = 16'($urandom);
        lat = 0;
        while (!b4.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("lat4", 32'(lat), 32'(r.lat));
        check("result4", 32'({b4.v, b4.singular, b4.check_err, b4.in_ready}),
              32'({r.v, r.sing, 1'b0, 1'b0}));
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
        check("release4", 32'({b4.out_valid, b4.in_ready}), 32'(2'b01));
    endtask

    initial begin
        res_t r;
        int   inv;
        int   ns0;
        int   s0;
        int   stray;

        b2.in_valid = 1'b0; b2.a = 4'd0;  b2.u = 2'd0; b2.out_ready = 1'b0;
        b4.in_valid = 1'b0; b4.a = 16'd0; b4.u = 4'd0; b4.out_ready = 1'b0;

        r = ref_solve(2, 16'h0009, 4'h2);
        check("pin_identity", 32'({r.v, r.sing, r.lat}), 32'({4'd2, 1'b0, 8'(4 + CHK)}));
        r = ref_solve(2, 16'h0006, 4'h1);
        check("pin_rowswap", 32'({r.v, r.sing, r.lat}), 32'({4'd2, 1'b0, 8'(4 + CHK)}));
        r = ref_solve(2, 16'h000B, 4'h2);
        check("pin_elim", 32'({r.v, r.sing, r.lat}), 32'({4'd3, 1'b0, 8'(4 + CHK)}));
        r = ref_solve(2, 16'h000F, 4'h1);
        check("pin_singular", 32'({r.v, r.sing, r.lat}), 32'({4'd0, 1'b1, 8'd3}));
        r = ref_solve(4, 16'h8421, 4'hA);
        check("pin_identity4", 32'({r.v, r.sing, r.lat}), 32'({4'hA, 1'b0, 8'(8 + CHK)}));
        inv = 0;
        for (int ai = 0; ai < 16; ai++) begin
            r = ref_solve(2, 16'(ai), 4'd0);
            if (!r.sing) inv++;
        end
        check("pin_invertible_count", 32'(inv), 32'd6);

        repeat (3) @(posedge clk);
        #1;
        check("reset4", 32'({b4.out_valid, b4.in_ready, b4.v, b4.singular, b4.check_err}),
              32'(8'b01000000));
        rst_n = 1'b1;

        solve2(4'b1001, 2'b10, 0);
        solve2(4'b0110, 2'b01, 0);
        solve2(4'b1011, 2'b10, 2);
        solve2(4'b1111, 2'b01, 0);

        ns0 = nsing2_cnt;
        s0  = sing2_cnt;
        for (int ai = 0; ai < 16; ai++) begin
            for (int ui = 0; ui < 4; ui++) begin
                solve2(4'(ai), 2'(ui), ($urandom_range(0, 3) == 0) ? 5 : 0);
            end
        end
        check("exh_nonsingular", 32'(nsing2_cnt - ns0), 32'd24);
        check("exh_singular", 32'(sing2_cnt - s0), 32'd40);

        // Abort an N=4 solve two edges after acceptance.
        b4.a = 16'($urandom) | 16'h8421;
        b4.u = 4'($urandom);
        b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset4", 32'({b4.out_valid, b4.in_ready, b4.v, b4.singular, b4.check_err}),
              32'(8'b01000000));
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (12) begin
            @(posedge clk); #1;
            stray += int'(b4.out_valid);
        end
        check("stray4", 32'(stray), 32'd0);
        solve4(16'h8421, 4'b1010);

        repeat (30) solve4(16'($urandom), 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
